// File: rtl/branch_pkg.sv
// Shared definitions for the branch predict unit.
//  - brOp encodings (5-bit, same as the legacy combinational branch block)
//  - bht_state_t: 2-bit bimodal counter states, prediction = MSB
//  - is_cond():   true only for the six compare opcodes
//  - bht_next():  saturating counter step toward the resolved outcome
package branch_pkg;

  localparam logic [4:0] BR_NONE = 5'b00000;
  localparam logic [4:0] BR_JUMP = 5'b10000;
  localparam logic [4:0] BR_EQ   = 5'b01000;
  localparam logic [4:0] BR_NE   = 5'b01001;
  localparam logic [4:0] BR_LT   = 5'b01100;
  localparam logic [4:0] BR_GE   = 5'b01101;
  localparam logic [4:0] BR_LTU  = 5'b01110;
  localparam logic [4:0] BR_GEU  = 5'b01111;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_state_t;

  // Only the six compare codes train the predictor; other 01xxx codes are no-ops.
  function automatic logic is_cond(input logic [4:0] op);
    case (op)
      BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU: is_cond = 1'b1;
      default:                                    is_cond = 1'b0;
    endcase
  endfunction

  function automatic bht_state_t bht_next(input bht_state_t s, input logic taken);
    case (s)
      BHT_SNT: bht_next = taken ? BHT_WNT : BHT_SNT;
      BHT_WNT: bht_next = taken ? BHT_WT  : BHT_SNT;
      BHT_WT:  bht_next = taken ? BHT_ST  : BHT_WNT;
      BHT_ST:  bht_next = taken ? BHT_ST  : BHT_WT;
      default: bht_next = BHT_WNT;
    endcase
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Pure branch comparator.
//  brOp   in  5     branch opcode
//  ruRs1  in  XLEN  first register operand
//  ruRs2  in  XLEN  second register operand
//  cmp    out 1     compare result for the six conditional codes, 0 otherwise
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      brOp,
  input  logic [XLEN-1:0] ruRs1,
  input  logic [XLEN-1:0] ruRs2,
  output logic            cmp
);

  // Operand comparison selected by opcode.
  always_comb begin
    cmp = 1'b0;
    case (brOp)
      BR_EQ:   cmp = (ruRs1 == ruRs2);
      BR_NE:   cmp = (ruRs1 != ruRs2);
      BR_LT:   cmp = ($signed(ruRs1) <  $signed(ruRs2));
      BR_GE:   cmp = ($signed(ruRs1) >= $signed(ruRs2));
      BR_LTU:  cmp = (ruRs1 <  ruRs2);
      BR_GEU:  cmp = (ruRs1 >= ruRs2);
      default: cmp = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution plus bimodal prediction.
//  clk, rst_n            core clock / async active-low reset
//  ifPc -> ifPredTaken   0-cycle BHT lookup for the fetch PC (MSB of counter)
//  exValid, exStall      EX qualifiers; a stalled EX never redirects or updates
//  exPc, exPredTaken     EX instruction PC and the prediction it was fetched with
//  exTarget, brOp        computed target and branch opcode
//  ruRs1, ruRs2          register operands
//  nextPcSrc             resolved taken
//  redirect, redirectPc  flush request and corrected fetch PC
//  brCount, missCount    saturating conditional-branch / mispredict counters
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  ifPc,
  output logic             ifPredTaken,
  input  logic             exValid,
  input  logic             exStall,
  input  logic [XLEN-1:0]  exPc,
  input  logic             exPredTaken,
  input  logic [XLEN-1:0]  exTarget,
  input  logic [4:0]       brOp,
  input  logic [XLEN-1:0]  ruRs1,
  input  logic [XLEN-1:0]  ruRs2,
  output logic             nextPcSrc,
  output logic             redirect,
  output logic [XLEN-1:0]  redirectPc,
  output logic [CNT_W-1:0] brCount,
  output logic [CNT_W-1:0] missCount
);

  localparam int               IDX_W   = $clog2(BHT_ENTRIES);
  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(32'd4);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  bht_state_t       bht_q [BHT_ENTRIES];
  bht_state_t       bht_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic             cmp, is_jump, is_cnd, taken, mispredict, upd_en;

  // PC bits outside the index field are intentionally ignored by the lookup.
  logic             unused_ifpc_bits;
  assign unused_ifpc_bits = ^{ifPc[XLEN-1:IDX_W+2], ifPc[1:0]};

  assign if_idx = ifPc[IDX_W+1:2];
  assign ex_idx = exPc[IDX_W+1:2];

  // No write bypass: a same-cycle update to if_idx is seen from the next cycle.
  assign ifPredTaken = (bht_q[if_idx] == BHT_WT) || (bht_q[if_idx] == BHT_ST);

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .brOp  (brOp),
    .ruRs1 (ruRs1),
    .ruRs2 (ruRs2),
    .cmp   (cmp)
  );

  // Resolve, redirect selection and next-state for BHT entry and counters.
  always_comb begin
    is_jump    = brOp[4];
    is_cnd     = is_cond(brOp);
    taken      = exValid & (is_jump | (is_cnd & cmp));
    mispredict = is_cnd & (taken != exPredTaken);
    // Jumps always redirect: without a BTB their target is only known here.
    redirect   = exValid & ~exStall & (is_jump | mispredict);
    redirectPc = taken ? exTarget : (exPc + PC_STEP);
    nextPcSrc  = taken;
    upd_en     = exValid & ~exStall & is_cnd;
    bht_d      = bht_next(bht_q[ex_idx], taken);
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (upd_en) begin
      if (br_cnt_q != CNT_MAX) begin
        br_cnt_d = br_cnt_q + CNT_ONE;
      end else begin
        br_cnt_d = br_cnt_q;
      end
      if (mispredict && (miss_cnt_q != CNT_MAX)) begin
        miss_cnt_d = miss_cnt_q + CNT_ONE;
      end else begin
        miss_cnt_d = miss_cnt_q;
      end
    end else begin
      br_cnt_d   = br_cnt_q;
      miss_cnt_d = miss_cnt_q;
    end
  end

  // BHT storage; reset drops every entry back to weakly-not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= BHT_WNT;
      end
    end else if (upd_en) begin
      bht_q[ex_idx] <= bht_d;
    end
  end

  // Performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign brCount   = br_cnt_q;
  assign missCount = miss_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ifPc, exPc, exTarget, ruRs1, ruRs2;
  logic        exValid, exStall, exPredTaken;
  logic [4:0]  brOp;

  logic        ifPredTaken, nextPcSrc, redirect;
  logic [31:0] redirectPc, brCount, missCount;
  logic        ifPredTaken4, nextPcSrc4, redirect4;
  logic [31:0] redirectPc4;
  logic [3:0]  brCount4, missCount4;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int     m_bht [64];
  longint m_br, m_miss, m_br4, m_miss4;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .rst_n(rst_n), .ifPc(ifPc), .ifPredTaken(ifPredTaken),
    .exValid(exValid), .exStall(exStall), .exPc(exPc), .exPredTaken(exPredTaken),
    .exTarget(exTarget), .brOp(brOp), .ruRs1(ruRs1), .ruRs2(ruRs2),
    .nextPcSrc(nextPcSrc), .redirect(redirect), .redirectPc(redirectPc),
    .brCount(brCount), .missCount(missCount)
  );

  branch_predict_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ifPc(ifPc), .ifPredTaken(ifPredTaken4),
    .exValid(exValid), .exStall(exStall), .exPc(exPc), .exPredTaken(exPredTaken),
    .exTarget(exTarget), .brOp(brOp), .ruRs1(ruRs1), .ruRs2(ruRs2),
    .nextPcSrc(nextPcSrc4), .redirect(redirect4), .redirectPc(redirectPc4),
    .brCount(brCount4), .missCount(missCount4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_is_cond(input logic [4:0] op);
    return op == 5'b01000 || op == 5'b01001 || op == 5'b01100 ||
           op == 5'b01101 || op == 5'b01110 || op == 5'b01111;
  endfunction

  function automatic bit m_cmp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int     sa = int'(a);
    int     sb = int'(b);
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    if (op == 5'b01000) return a == b;
    if (op == 5'b01001) return a != b;
    if (op == 5'b01100) return sa < sb;
    if (op == 5'b01101) return sa >= sb;
    if (op == 5'b01110) return ua < ub;
    if (op == 5'b01111) return ua >= ub;
    return 1'b0;
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_bht[int'(pc[7:2])] >= 2;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_br = 0; m_miss = 0; m_br4 = 0; m_miss4 = 0;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                       input logic valid, input logic stall, input logic [31:0] ipc);
    brOp = op; ruRs1 = a; ruRs2 = b; exPc = pc; exTarget = tgt;
    exPredTaken = pred; exValid = valid; exStall = stall; ifPc = ipc;
  endtask

  // Called in the low clock phase with inputs driven; checks comb outputs,
  // crosses one rising edge, checks counters, returns at the next falling edge.
  task automatic step();
    bit jump, cond, tk, rd, miss;
    logic [31:0] rpc;
    int idx;
    #1;
    jump = brOp[4];
    cond = m_is_cond(brOp);
    tk   = exValid && (jump || (cond && m_cmp(brOp, ruRs1, ruRs2)));
    miss = cond && (tk != exPredTaken);
    rd   = exValid && !exStall && (jump || miss);
    rpc  = tk ? exTarget : exPc + 32'd4;
    chk("nextPcSrc", {63'd0, nextPcSrc}, {63'd0, tk});
    chk("redirect", {63'd0, redirect}, {63'd0, rd});
    chk("redirectPc", {32'd0, redirectPc}, {32'd0, rpc});
    chk("ifPredTaken", {63'd0, ifPredTaken}, {63'd0, m_pred(ifPc)});
    chk("redirect_w4", {63'd0, redirect4}, {63'd0, rd});
    chk("ifPredTaken_w4", {63'd0, ifPredTaken4}, {63'd0, m_pred(ifPc)});
    @(posedge clk);
    if (exValid && !exStall && cond) begin
      idx = int'(exPc[7:2]);
      if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
      else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
      m_br  = (m_br  < 64'hFFFFFFFF) ? m_br + 1 : m_br;
      m_br4 = (m_br4 < 15) ? m_br4 + 1 : m_br4;
      if (miss) begin
        m_miss  = (m_miss  < 64'hFFFFFFFF) ? m_miss + 1 : m_miss;
        m_miss4 = (m_miss4 < 15) ? m_miss4 + 1 : m_miss4;
      end
    end
    #1;
    chk("brCount", {32'd0, brCount}, m_br);
    chk("missCount", {32'd0, missCount}, m_miss);
    chk("brCount_w4", {60'd0, brCount4}, m_br4);
    chk("missCount_w4", {60'd0, missCount4}, m_miss4);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exValid = 1'b0;
    #2;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        pred;
    logic        exp_taken;
    logic        exp_redirect;
  } vec_t;

  vec_t vecs [14];
  logic [4:0] ops [11];

  initial begin
    logic [31:0] tmp_br, tmp_miss, pc, a, b;
    logic [4:0]  op;

    vecs[0]  = '{5'b01000, 32'd5,        32'd5,          1'b0, 1'b1, 1'b1};
    vecs[1]  = '{5'b01000, 32'd5,        32'd6,          1'b0, 1'b0, 1'b0};
    vecs[2]  = '{5'b01001, 32'd5,        32'd6,          1'b1, 1'b1, 1'b0};
    vecs[3]  = '{5'b01100, 32'hFFFFFFFF, 32'd1,          1'b0, 1'b1, 1'b1};
    vecs[4]  = '{5'b01110, 32'hFFFFFFFF, 32'd1,          1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'b01110, 32'hFFFFFFFF, 32'd1,          1'b1, 1'b0, 1'b1};
    vecs[6]  = '{5'b01101, 32'd1,        32'hFFFFFFFF,   1'b1, 1'b1, 1'b0};
    vecs[7]  = '{5'b01111, 32'd1,        32'hFFFFFFFF,   1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'b01101, 32'd3,        32'd3,          1'b0, 1'b1, 1'b1};
    vecs[9]  = '{5'b01111, 32'd3,        32'd3,          1'b1, 1'b1, 1'b0};
    vecs[10] = '{5'b00000, 32'd5,        32'd5,          1'b1, 1'b0, 1'b0};
    vecs[11] = '{5'b01010, 32'd5,        32'd5,          1'b1, 1'b0, 1'b0};
    vecs[12] = '{5'b10000, 32'd0,        32'd1,          1'b0, 1'b1, 1'b1};
    vecs[13] = '{5'b11111, 32'd0,        32'd1,          1'b1, 1'b1, 1'b1};

    ops = '{5'b00000, 5'b00101, 5'b01010, 5'b01000, 5'b01001, 5'b01100,
            5'b01101, 5'b01110, 5'b01111, 5'b10000, 5'b11011};

    // Reset state
    rst_n = 1'b0;
    drive(5'b00000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    m_reset();
    #3;
    chk("rst_brCount", {32'd0, brCount}, 64'd0);
    chk("rst_missCount", {32'd0, missCount}, 64'd0);
    chk("rst_ifPredTaken", {63'd0, ifPredTaken}, 64'd0);
    chk("rst_redirect", {63'd0, redirect}, 64'd0);
    chk("rst_redirectPc", {32'd0, redirectPc}, 64'd4);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: BEQ at 0x100 taken, predicted not taken
    drive(5'b01000, 32'd5, 32'd5, 32'h100, 32'h2000, 1'b0, 1'b1, 1'b0, 32'h100);
    #1;
    chk("t1_redirect", {63'd0, redirect}, 64'd1);
    chk("t1_redirectPc", {32'd0, redirectPc}, 64'h2000);
    chk("t1_pred_before", {63'd0, ifPredTaken}, 64'd0);
    step();
    drive(5'b00000, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h100);
    #1;
    chk("t1_bht0_after", {63'd0, ifPredTaken}, 64'd1);
    chk("t1_missCount", {32'd0, missCount}, 64'd1);
    step();

    // Vector table (pc 0x40, target 0x800)
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 32'h40, 32'h800, vecs[i].pred, 1'b1, 1'b0, 32'h40);
      #1;
      chk($sformatf("vec%0d_taken", i), {63'd0, nextPcSrc}, {63'd0, vecs[i].exp_taken});
      chk($sformatf("vec%0d_redirect", i), {63'd0, redirect}, {63'd0, vecs[i].exp_redirect});
      chk($sformatf("vec%0d_redirectPc", i), {32'd0, redirectPc},
          vecs[i].exp_taken ? 64'h800 : 64'h44);
      step();
    end

    // Test 3: BNE taken 4x at one PC
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(5'b01001, 32'd1, 32'd2, 32'h208, 32'h300, m_pred(32'h208), 1'b1, 1'b0, 32'h208);
      step();
      drive(5'b00000, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h208);
      #1;
      chk($sformatf("t3_pred_%0d", i), {63'd0, ifPredTaken}, 64'd1);
    end
    chk("t3_brCount", {32'd0, brCount}, 64'd4);
    chk("t3_missCount", {32'd0, missCount}, 64'd1);
    step();

    // Test 4: jump stalled then released
    tmp_br = brCount; tmp_miss = missCount;
    drive(5'b10000, 32'd0, 32'd0, 32'h208, 32'h1234, 1'b0, 1'b1, 1'b1, 32'h208);
    #1;
    chk("t4_redirect_stalled", {63'd0, redirect}, 64'd0);
    step();
    drive(5'b10000, 32'd0, 32'd0, 32'h208, 32'h1234, 1'b0, 1'b1, 1'b0, 32'h208);
    #1;
    chk("t4_redirect", {63'd0, redirect}, 64'd1);
    chk("t4_redirectPc", {32'd0, redirectPc}, 64'h1234);
    step();
    chk("t4_brCount_held", {32'd0, brCount}, {32'd0, tmp_br});
    chk("t4_missCount_held", {32'd0, missCount}, {32'd0, tmp_miss});
    chk("t4_bht_held", {63'd0, ifPredTaken}, 64'd1);

    // Test 5: same-cycle update and lookup at idx 3, then PC wrap
    do_reset();
    drive(5'b01000, 32'd9, 32'd9, 32'h00C, 32'h500, 1'b0, 1'b1, 1'b0, 32'h00C);
    #1;
    chk("t5_no_bypass", {63'd0, ifPredTaken}, 64'd0);
    step();
    drive(5'b00000, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h00C);
    #1;
    chk("t5_next_cycle", {63'd0, ifPredTaken}, 64'd1);
    step();
    drive(5'b01001, 32'd7, 32'd7, 32'hFFFFFFFC, 32'h600, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("t5_wrapPc", {32'd0, redirectPc}, 64'd0);
    chk("t5_wrap_redirect", {63'd0, redirect}, 64'd0);
    step();

    // Test 6: async reset in the middle of an update cycle
    do_reset();
    drive(5'b01000, 32'd1, 32'd1, 32'h010, 32'h700, 1'b0, 1'b1, 1'b0, 32'h010);
    step();
    drive(5'b01000, 32'd1, 32'd1, 32'h010, 32'h700, 1'b1, 1'b1, 1'b0, 32'h010);
    #1;
    chk("t6_pred_pre", {63'd0, ifPredTaken}, 64'd1);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("t6_pred_rst", {63'd0, ifPredTaken}, 64'd0);
    chk("t6_brCount_rst", {32'd0, brCount}, 64'd0);
    chk("t6_missCount_rst", {32'd0, missCount}, 64'd0);
    chk("t6_brCount4_rst", {60'd0, brCount4}, 64'd0);
    @(posedge clk);
    #1;
    chk("t6_discarded", {32'd0, brCount}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation: 20 mispredicted taken branches
    for (int i = 0; i < 20; i++) begin
      drive(5'b01000, 32'd4, 32'd4, 32'(i) << 2, 32'h900, 1'b0, 1'b1, 1'b0, 32'h0);
      step();
    end
    chk("t6_brCount4_sat", {60'd0, brCount4}, 64'd15);
    chk("t6_missCount4_sat", {60'd0, missCount4}, 64'd15);
    chk("t6_brCount32", {32'd0, brCount}, 64'd20);
    chk("t6_missCount32", {32'd0, missCount}, 64'd20);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      op = ops[$urandom_range(0, 10)];
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : (32'($urandom_range(0, 127)) << 2);
      a  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4));
      b  = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom
                                                                         : 32'($urandom_range(0, 4)));
      drive(op, a, b, pc, $urandom,
            ($urandom_range(0, 3) == 0) ? 1'($urandom) : 1'(m_pred(pc)),
            $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
            ($urandom_range(0, 1) == 1) ? pc : (32'($urandom_range(0, 127)) << 2));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
